// File: rtl/handshake_fifo_if.sv
// rtl/handshake_fifo_if.sv - producer/consumer valid-ready bundle around handshake_fifo
interface handshake_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
);
  logic              d_valid_i;
  logic [DATA_W-1:0] d_data_i;
  logic              d_ready_o;
  logic              s_valid_o;
  logic [DATA_W-1:0] s_data_o;
  logic              s_ready_i;
  logic [AW:0]       level_o;

  // FIFO side of the bundle
  modport slave (
    input  d_valid_i, d_data_i, s_ready_i,
    output d_ready_o, s_valid_o, s_data_o, level_o
  );

  // Producer/consumer side of the bundle
  modport master (
    output d_valid_i, d_data_i, s_ready_i,
    input  d_ready_o, s_valid_o, s_data_o, level_o
  );
endinterface

// File: rtl/handshake_fifo.sv
// rtl/handshake_fifo.sv - first-word-fall-through valid/ready FIFO with registered-only ready paths
module handshake_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  handshake_fifo_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wp;
  logic [AW:0]       rp;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // Flags depend only on the pointer registers, keeping s_ready_i out of d_ready_o.
  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);

  assign push = bus.d_valid_i && !full;
  assign pop  = bus.s_ready_i && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= bus.d_data_i;
        wp              <= wp + (AW+1)'(1);
      end
      if (pop) begin
        rp <= rp + (AW+1)'(1);
      end
    end
  end

  assign bus.d_ready_o = !full;
  assign bus.s_valid_o = !empty;
  assign bus.s_data_o  = mem[rp[AW-1:0]];
  assign bus.level_o   = wp - rp;

endmodule

// File: tb/tb_handshake_fifo.sv
// tb/tb_handshake_fifo.sv - randomized scoreboard bench for handshake_fifo
module tb_handshake_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [DATA_W-1:0] exp_q[$];

  handshake_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  handshake_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: an ideal FIFO is just an ordered list of accepted words, capped at DEPTH.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("level", 32'(bus.level_o), 32'(exp_q.size()));
      check("d_ready", 32'(bus.d_ready_o), 32'(exp_q.size() < DEPTH));
      check("s_valid", 32'(bus.s_valid_o), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0 && bus.s_valid_o === 1'b1)
        check("s_data", 32'(bus.s_data_o), 32'(exp_q[0]));
      if (bus.s_valid_o === 1'b1 && bus.s_ready_i && exp_q.size() > 0)
        void'(exp_q.pop_front());
      if (bus.d_valid_i && bus.d_ready_o === 1'b1 && exp_q.size() < DEPTH)
        exp_q.push_back(bus.d_data_i);
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] v);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    bus.d_valid_i = 1'b1;
    bus.d_data_i  = v;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.d_ready_o === 1'b1) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("push_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    bus.d_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    bus.d_valid_i = 1'b0;
    bus.s_ready_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.level_o === '0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lvl0;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.d_valid_i = 1'b1;
    bus.d_data_i  = 8'hEE;
    bus.s_ready_i = 1'b0;

    // Reset held two cycles with a push request pending
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_valid", 32'(bus.s_valid_o), 32'(0));
    check("rst_d_ready", 32'(bus.d_ready_o), 32'(1));
    check("rst_level", 32'(bus.level_o), 32'(0));
    check("rst_s_data", 32'(bus.s_data_o), 32'(0));
    rst = 1'b0;
    bus.d_valid_i = 1'b0;

    // Single word with consumer ready
    @(posedge clk); #1;
    bus.s_ready_i = 1'b1;
    push_word(8'hA5);
    @(negedge clk);
    check("single_valid", 32'(bus.s_valid_o), 32'(1));
    check("single_data", 32'(bus.s_data_o), 32'(8'hA5));
    @(negedge clk);
    check("single_level", 32'(bus.level_o), 32'(0));

    // Fill to full, then an extra word must wait for space
    @(posedge clk); #1;
    bus.s_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    @(posedge clk); #1;
    bus.d_valid_i = 1'b1;
    bus.d_data_i  = 8'h05;
    repeat (3) begin
      @(negedge clk);
      check("full_d_ready", 32'(bus.d_ready_o), 32'(0));
      check("full_level", 32'(bus.level_o), 32'(4));
    end
    @(posedge clk); #1;
    bus.s_ready_i = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (bus.d_ready_o === 1'b1) ok = 1'b1;
      end
      if (!ok) check("full_release_timeout", 32'(0), 32'(1));
    end
    @(posedge clk); #1;
    bus.d_valid_i = 1'b0;
    drain();

    // Simultaneous push/pop at level 2
    @(posedge clk); #1;
    bus.s_ready_i = 1'b0;
    push_word(8'h40);
    push_word(8'h41);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.d_valid_i = 1'b1;
      bus.d_data_i  = 8'($urandom);
      bus.s_ready_i = 1'b1;
      @(negedge clk);
      check("simul_level", 32'(bus.level_o), 32'(2));
    end
    drain();

    // Stall stability with 0x3C at the head
    @(posedge clk); #1;
    bus.s_ready_i = 1'b0;
    push_word(8'h3C);
    @(negedge clk);
    lvl0 = 32'(bus.level_o);
    push_word(8'h11);
    push_word(8'h22);
    @(negedge clk);
    check("stall_data", 32'(bus.s_data_o), 32'(8'h3C));
    check("stall_level", 32'(bus.level_o), lvl0 + 32'd2);
    drain();

    // Mid-stream reset with push and pop requested in the reset cycle
    @(posedge clk); #1;
    bus.s_ready_i = 1'b0;
    push_word(8'h61);
    push_word(8'h62);
    push_word(8'h63);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.d_valid_i = 1'b1;
    bus.d_data_i  = 8'h99;
    bus.s_ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.d_valid_i = 1'b0;
    bus.s_ready_i = 1'b0;
    @(negedge clk);
    check("mrst_level", 32'(bus.level_o), 32'(0));
    check("mrst_s_valid", 32'(bus.s_valid_o), 32'(0));
    push_word(8'h77);
    @(negedge clk);
    check("mrst_first", 32'(bus.s_data_o), 32'(8'h77));
    drain();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 79) == 0);
      bus.d_valid_i = 1'($urandom_range(0, 1));
      bus.d_data_i  = 8'($urandom);
      bus.s_ready_i = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drain();
    @(negedge clk);
    check("end_level", 32'(bus.level_o), 32'(0));
    check("end_model_empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
